window_gen_3x3: RTL

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

---
 rtl/window_gen_3x3.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//
// Builds a registered 3x3 pixel window from a raster-order pixel stream.
// Two line buffers hold the previous two rows; three column shift stages
// (the output window registers themselves) provide the last three columns.
//
// Parameters
//   WIDTH  : pixels per row (at most 1024, coordinates are 10 bits)
//   HEIGHT : rows per frame (at most 1024)
//   DW     : bits per pixel
//
// Ports
//   clk        : clock, all state updates on rising edge
//   reset      : asynchronous active-high reset
//   pix_in     : raster-order pixel, top-left first
//   pix_valid  : pix_in accepted on every edge where this is high
//   w0..w8     : 3x3 window, w0 top-left, w4 centre, w8 bottom-right
//   win_valid  : window is complete and lies entirely inside one frame
//   ctr_row    : frame row of the window centre (w4)
//   ctr_col    : frame column of the window centre (w4)
//   frame_done : one-cycle pulse on the edge accepting the last frame pixel
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
   parameter int unsigned WIDTH  = 800,
   parameter int unsigned HEIGHT = 600,
   parameter int unsigned DW     = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] pix_in,
   input  logic          pix_valid,
   output logic [DW-1:0] w0,
   output logic [DW-1:0] w1,
   output logic [DW-1:0] w2,
   output logic [DW-1:0] w3,
   output logic [DW-1:0] w4,
   output logic [DW-1:0] w5,
   output logic [DW-1:0] w6,
   output logic [DW-1:0] w7,
   output logic [DW-1:0] w8,
   output logic          win_valid,
   output logic [9:0]    ctr_row,
   output logic [9:0]    ctr_col,
   output logic          frame_done
);

   localparam int unsigned CW = 10;
   localparam logic [CW-1:0] LastCol = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LastRow = CW'(HEIGHT - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CW-1:0]        col_q, col_d;
   logic [CW-1:0]        row_q, row_d;
   logic [8:0][DW-1:0]   win_q, win_d;
   logic                 valid_q, valid_d;
   logic                 done_q, done_d;
   logic [CW-1:0]        ctr_row_q, ctr_row_d;
   logic [CW-1:0]        ctr_col_q, ctr_col_d;

   // lb_mid holds row r-1, lb_top holds row r-2, both indexed by column.
   logic [DW-1:0]        lb_mid [WIDTH];
   logic [DW-1:0]        lb_top [WIDTH];
   logic [DW-1:0]        mid_rd;
   logic [DW-1:0]        top_rd;

   logic                 last_col;
   logic                 last_row;

   assign mid_rd   = lb_mid[col_q];
   assign top_rd   = lb_top[col_q];
   assign last_col = (col_q == LastCol);
   assign last_row = (row_q == LastRow);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      win_d     = win_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      ctr_row_d = ctr_row_q;
      ctr_col_d = ctr_col_q;

      if (pix_valid) begin
         // Raster position of the next pixel.
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         // Each window row shifts left by one column; the right-hand column
         // is fed from the two line buffers and the incoming pixel.
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = top_rd;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = mid_rd;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = pix_in;

         // Windows touching row 0/1 or columns 0/1 would reach into the
         // previous row or frame, so only interior centres are flagged.
         valid_d   = (row_q >= CW'(2)) && (col_q >= CW'(2));
         done_d    = last_col && last_row;
         ctr_row_d = row_q - 1'b1;
         ctr_col_d = col_q - 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q     <= '0;
         row_q     <= '0;
         win_q     <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         ctr_row_q <= '0;
         ctr_col_q <= '0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         win_q     <= win_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         ctr_row_q <= ctr_row_d;
         ctr_col_q <= ctr_col_d;
      end
   end

   // Line buffers are not reset: stale contents only ever reach windows that
   // win_valid already marks invalid.
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb_top[col_q] <= mid_rd;
         lb_mid[col_q] <= pix_in;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign w0         = win_q[0];
   assign w1         = win_q[1];
   assign w2         = win_q[2];
   assign w3         = win_q[3];
   assign w4         = win_q[4];
   assign w5         = win_q[5];
   assign w6         = win_q[6];
   assign w7         = win_q[7];
   assign w8         = win_q[8];
   assign win_valid  = valid_q;
   assign frame_done = done_q;
   assign ctr_row    = ctr_row_q;
   assign ctr_col    = ctr_col_q;

endmodule
